// File: rtl/strassen_quadrant_combiner.sv
// Strassen back-end: folds the seven M product streams into the four C quadrant
// elements, then saturates or wraps them through a stallable two-stage pipeline.
module strassen_quadrant_combiner #(
  parameter int TILE_DIM  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 24,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                   fast_clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7*ACC_WIDTH-1:0] m_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*OUT_WIDTH-1:0] c_data,
  output logic                   out_last,
  output logic                   tile_done,
  output logic                   ovf_sticky
);

  localparam int SW    = ACC_WIDTH + 2;
  localparam int NELEM = TILE_DIM * TILE_DIM;
  localparam int CW    = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam logic [CW-1:0]        CNT_MAX = CW'(NELEM - 1);
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef logic signed [SW-1:0] sum_t;

  // Returns {changed, formatted}: changed is set whenever the OUT_WIDTH result
  // no longer equals the exact sum, for either clamping or wrapping.
  function automatic logic [OUT_WIDTH:0] fmt_elem(input logic [SW-1:0] v);
    logic [OUT_WIDTH-1:0] wrapped;
    logic [SW-1:0]        back;
    logic                 changed;
    wrapped = v[OUT_WIDTH-1:0];
    back    = SW'($signed(wrapped));
    changed = (back != v);
    if (SATURATE && changed) return {1'b1, (v[SW-1] ? SAT_MIN : SAT_MAX)};
    return {changed, wrapped};
  endfunction

  logic                          s1_valid_q, s1_valid_d;
  logic                          s1_last_q, s1_last_d;
  logic [3:0][SW-1:0]            s1_sum_q, s1_sum_d;
  logic                          s2_valid_q, s2_valid_d;
  logic                          s2_last_q, s2_last_d;
  logic [3:0][OUT_WIDTH-1:0]     s2_c_q, s2_c_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          tile_done_q, tile_done_d;
  logic                          ovf_sticky_q, ovf_sticky_d;

  sum_t                      m_ext [7];
  logic [3:0][SW-1:0]        exact_sum;
  logic [3:0][OUT_WIDTH-1:0] c_fmt;
  logic [3:0]                q_ovf;
  logic                      s1_en, s2_en, in_hs, out_hs, in_last;

  always_comb begin
    for (int i = 0; i < 7; i++) begin
      m_ext[i] = SW'($signed(m_data[i*ACC_WIDTH +: ACC_WIDTH]));
    end
    exact_sum[0] = m_ext[0] + m_ext[3] - m_ext[4] + m_ext[6];
    exact_sum[1] = m_ext[2] + m_ext[4];
    exact_sum[2] = m_ext[1] + m_ext[3];
    exact_sum[3] = m_ext[0] - m_ext[1] + m_ext[2] + m_ext[5];
  end

  always_comb begin
    for (int q = 0; q < 4; q++) begin
      {q_ovf[q], c_fmt[q]} = fmt_elem(s1_sum_q[q]);
    end
  end

  // Ready propagates backwards purely from pipeline occupancy, never from in_valid.
  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;
  assign in_hs    = in_valid && s1_en && !flush;
  assign out_hs   = s2_valid_q && out_ready;
  assign in_last  = (cnt_q == CNT_MAX);

  always_comb begin
    // NOTE: every _d starts as a copy of its _q so no path through this block
    // leaves a signal unassigned, which would otherwise infer a latch.
    s1_valid_d   = s1_valid_q;
    s1_last_d    = s1_last_q;
    s1_sum_d     = s1_sum_q;
    s2_valid_d   = s2_valid_q;
    s2_last_d    = s2_last_q;
    s2_c_d       = s2_c_q;
    cnt_d        = cnt_q;
    tile_done_d  = 1'b0;
    ovf_sticky_d = ovf_sticky_q;
    if (flush) begin
      s1_valid_d   = 1'b0;
      s2_valid_d   = 1'b0;
      s2_last_d    = 1'b0;
      cnt_d        = '0;
      ovf_sticky_d = 1'b0;
    end else begin
      tile_done_d = out_hs && s2_last_q;
      if (s1_en) begin
        s1_valid_d = in_hs;
        if (in_hs) begin
          s1_sum_d  = exact_sum;
          s1_last_d = in_last;
          cnt_d     = in_last ? '0 : cnt_q + CW'(1);
        end
      end
      if (s2_en) begin
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_valid_q && s1_last_q;
        if (s1_valid_q) begin
          s2_c_d       = c_fmt;
          ovf_sticky_d = ovf_sticky_q | (|q_ovf);
        end
      end
    end
  end

  // NOTE: the datapath registers are few and c_data must read zero out of reset,
  // so they share the async reset with the control flops.
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_sum_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_c_q       <= '0;
      cnt_q        <= '0;
      tile_done_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep all flops sampling pre-edge values.
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_sum_q     <= s1_sum_d;
      s2_valid_q   <= s2_valid_d;
      s2_last_q    <= s2_last_d;
      s2_c_q       <= s2_c_d;
      cnt_q        <= cnt_d;
      tile_done_q  <= tile_done_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_last   = s2_last_q;
  assign c_data     = s2_c_q;
  assign tile_done  = tile_done_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_strassen_quadrant_combiner.sv
// Bench for strassen_quadrant_combiner: a saturating 4x4-tile instance and a
// wrapping 1x1-tile instance share stimulus and are scored against a queue model.
module tb_strassen_quadrant_combiner;

  localparam int AW  = 8;
  localparam int OW  = 8;
  localparam int N_A = 16;

  logic            fast_clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [7*AW-1:0] m_data = '0;

  logic            in_ready_a, out_valid_a, out_last_a, tile_done_a, ovf_a;
  logic [4*OW-1:0] c_a;
  logic            in_ready_w, out_valid_w, out_last_w, tile_done_w, ovf_w;
  logic [4*OW-1:0] c_w;

  strassen_quadrant_combiner #(.TILE_DIM(4), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SATURATE(1'b1)) dut_a (
    .fast_clk(fast_clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .m_data(m_data), .out_valid(out_valid_a), .out_ready(out_ready), .c_data(c_a),
    .out_last(out_last_a), .tile_done(tile_done_a), .ovf_sticky(ovf_a));

  strassen_quadrant_combiner #(.TILE_DIM(1), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SATURATE(1'b0)) dut_w (
    .fast_clk(fast_clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w),
    .m_data(m_data), .out_valid(out_valid_w), .out_ready(out_ready), .c_data(c_w),
    .out_last(out_last_w), .tile_done(tile_done_w), .ovf_sticky(ovf_w));

  always #5 fast_clk = ~fast_clk;

  typedef struct {
    logic [31:0] ca;
    logic [31:0] cw;
    bit          last_a;
    bit          ovf;
  } item_t;

  item_t sb_a[$];
  item_t sb_w[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cnt_a = 0;
  bit    ovf_seen_a = 0, ovf_seen_w = 0;
  bit    exp_td_a = 0, exp_td_w = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Plain-integer reference: exact sums, then clamp or keep low byte.
  function automatic item_t model(input logic [7*AW-1:0] md, input bit last);
    item_t it;
    int    m[7];
    int    c[4];
    int    s;
    for (int i = 0; i < 7; i++) m[i] = int'($signed(md[i*AW +: AW]));
    c[0] = m[0] + m[3] - m[4] + m[6];
    c[1] = m[2] + m[4];
    c[2] = m[1] + m[3];
    c[3] = m[0] - m[1] + m[2] + m[5];
    it.ca = '0; it.cw = '0; it.ovf = 0; it.last_a = last;
    for (int q = 0; q < 4; q++) begin
      s = (c[q] > 127) ? 127 : (c[q] < -128) ? -128 : c[q];
      it.ca[q*8 +: 8] = 8'(s);
      it.cw[q*8 +: 8] = 8'(c[q]);
      if (c[q] > 127 || c[q] < -128) it.ovf = 1;
    end
    return it;
  endfunction

  task automatic clear_model();
    sb_a.delete(); sb_w.delete();
    cnt_a = 0; ovf_seen_a = 0; ovf_seen_w = 0; exp_td_a = 0; exp_td_w = 0;
  endtask

  // One clock: sample at negedge, score, update model, return at posedge+1.
  task automatic step();
    item_t h;
    bit    hs_a, hs_w, td_a, td_w;
    @(negedge fast_clk);
    check("tile_done_a", tile_done_a, exp_td_a);
    check("tile_done_w", tile_done_w, exp_td_w);
    check("in_ready_a", in_ready_a, (sb_a.size() < 2) || out_ready);
    check("in_ready_w", in_ready_w, (sb_w.size() < 2) || out_ready);
    td_a = 0; td_w = 0;
    hs_a = out_valid_a && out_ready;
    hs_w = out_valid_w && out_ready;
    if (out_valid_a) begin
      if (sb_a.size() == 0) check("spurious_a", out_valid_a, 1'b0);
      else begin
        check("c_data_a", c_a, sb_a[0].ca);
        check("out_last_a", out_last_a, sb_a[0].last_a);
        check("ovf_a", ovf_a, ovf_seen_a | sb_a[0].ovf);
        if (hs_a) begin
          h = sb_a.pop_front();
          ovf_seen_a |= h.ovf;
          td_a = h.last_a;
        end
      end
    end
    if (out_valid_w) begin
      if (sb_w.size() == 0) check("spurious_w", out_valid_w, 1'b0);
      else begin
        check("c_data_w", c_w, sb_w[0].cw);
        check("out_last_w", out_last_w, 1'b1);
        check("ovf_w", ovf_w, ovf_seen_w | sb_w[0].ovf);
        if (hs_w) begin
          h = sb_w.pop_front();
          ovf_seen_w |= h.ovf;
          td_w = 1;
        end
      end
    end
    if (flush) clear_model();
    else begin
      exp_td_a = td_a;
      exp_td_w = td_w;
      if (in_valid && in_ready_a) begin
        h = model(m_data, cnt_a == N_A - 1);
        sb_a.push_back(h);
        cnt_a = (cnt_a + 1) % N_A;
      end
      if (in_valid && in_ready_w) sb_w.push_back(model(m_data, 1'b1));
    end
    @(posedge fast_clk);
    #1;
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) begin
      m_data = {$urandom, $urandom};
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) if (sb_a.size() + sb_w.size() != 0) step();
    check("drain_a", sb_a.size(), 0);
    check("drain_w", sb_w.size(), 0);
    step();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    in_valid = 1'b1;
    m_data = {$urandom, $urandom};
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid_a, 1'b0);
    check("flush_ovf", ovf_a, 1'b0);
    check("flush_td", tile_done_a, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge fast_clk);
    #1;
    check("rst_valid", out_valid_a, 1'b0);
    check("rst_c", c_a, 32'h0);
    check("rst_last", out_last_a, 1'b0);
    check("rst_ovf", ovf_a, 1'b0);
    rst_n = 1'b1;

    // Basic combine with two-cycle latency
    out_ready = 1'b1;
    m_data = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_t1", out_valid_a, 1'b0);
    step();
    check("lat_t2", out_valid_a, 1'b1);
    check("basic_c", c_a, 32'h08060807);
    check("basic_ovf", ovf_a, 1'b0);
    step();

    // Finish the current tile, then one full back-to-back tile
    send_random(15);
    send_random(16);
    drain();

    // Backpressure mid-stream
    in_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      out_ready = !(i >= 3 && i < 8);
      m_data = {$urandom, $urandom};
      step();
      if (i == 5) check("bp_in_ready", in_ready_a, 1'b0);
    end
    drain();

    // Saturation vs wrap: M1=M4=M7=127, M5=-128, C11 exact = 509
    do_flush();
    m_data = {8'h7F, 8'h00, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h7F};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("sat_c", c_a, 32'h7F7F807F);
    check("wrap_c", c_w, 32'h7F7F80FD);
    check("sat_ovf", ovf_a, 1'b1);
    check("wrap_ovf", ovf_w, 1'b1);
    step();

    // Flush mid-tile with elements in flight, then a full fresh tile
    send_random(5);
    do_flush();
    send_random(16);
    drain();

    // Asynchronous reset mid-stream
    send_random(6);
    in_valid = 1'b1;
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_valid", out_valid_a, 1'b0);
    check("arst_c", c_a, 32'h0);
    check("arst_last", out_last_a, 1'b0);
    check("arst_td", tile_done_a, 1'b0);
    check("arst_ovf", ovf_a, 1'b0);
    clear_model();
    @(posedge fast_clk);
    #1 rst_n = 1'b1;
    send_random(16);
    drain();

    // Random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      m_data    = {$urandom, $urandom};
      step();
    end
    flush = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
